// File: rtl/clk_div_ctrl.sv
// Programmable clock-enable controller: sequences a half-period divider that
// produces a square wave `out`, a `tick` on every rising edge of `out`, and
// always ends a run on a low phase so no truncated high pulse escapes.
module clk_div_ctrl #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned BURST_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_div,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               start,
    input  logic               stop,
    output logic               out,
    output logic               tick,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [BURST_W-1:0] tick_count
);

    typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   div_reg_q, div_reg_d;
    logic [BURST_W-1:0] burst_reg_q, burst_reg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_q, out_d;
    logic               tick_q, tick_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [BURST_W-1:0] tc_q, tc_d;

    logic [CNT_W-1:0]   eff_div;
    logic [CNT_W-1:0]   cnt_next;
    logic [BURST_W-1:0] tc_inc;
    logic               at_end;
    logic               rise;
    logic               fall;
    logic               last_tick;

    // Divider datapath helpers shared by RUN and FINISH.
    always_comb begin
        // A config word accepted on the same edge as start is the one the run uses.
        eff_div   = cfg_valid ? cfg_div : div_reg_q;
        at_end    = (cnt_q == (div_reg_q - CNT_W'(1)));
        cnt_next  = at_end ? '0 : cnt_q + CNT_W'(1);
        rise      = at_end && !out_q;
        fall      = at_end && out_q;
        tc_inc    = tc_q + BURST_W'(1);
        last_tick = rise && (burst_reg_q != '0) && (tc_inc == burst_reg_q);
    end

    // Next-state and output decode for the IDLE / RUN / FINISH sequencer.
    always_comb begin
        state_d     = state_q;
        div_reg_d   = div_reg_q;
        burst_reg_d = burst_reg_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        tc_d        = tc_q;
        tick_d      = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cfg_valid) begin
                    div_reg_d   = cfg_div;
                    burst_reg_d = cfg_burst;
                end
                if (start) begin
                    if (eff_div == '0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = StRun;
                        cnt_d   = '0;
                        out_d   = 1'b0;
                        tc_d    = '0;
                    end
                end
            end
            StRun: begin
                cnt_d = cnt_next;
                out_d = out_q ^ at_end;
                if (rise) begin
                    tick_d = 1'b1;
                    tc_d   = tc_inc;
                end
                if (last_tick) begin
                    // Final burst tick wins over a coincident stop: one FINISH, one done.
                    state_d = StFinish;
                end else if (stop) begin
                    if (!out_q || fall) begin
                        // Already low (or falling now): end immediately, suppress any rise.
                        state_d = StIdle;
                        done_d  = 1'b1;
                        out_d   = 1'b0;
                        cnt_d   = '0;
                        tick_d  = 1'b0;
                        tc_d    = tc_q;
                    end else begin
                        state_d = StFinish;
                    end
                end
            end
            StFinish: begin
                cnt_d = cnt_next;
                out_d = out_q ^ at_end;
                // Only the falling toggle can occur here, so no tick is ever issued.
                if (fall) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            div_reg_q   <= '0;
            burst_reg_q <= '0;
            cnt_q       <= '0;
            out_q       <= 1'b0;
            tick_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            tc_q        <= '0;
        end else begin
            state_q     <= state_d;
            div_reg_q   <= div_reg_d;
            burst_reg_q <= burst_reg_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            tick_q      <= tick_d;
            done_q      <= done_d;
            err_q       <= err_d;
            tc_q        <= tc_d;
        end
    end

    assign cfg_ready  = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign out        = out_q;
    assign tick       = tick_q;
    assign done       = done_q;
    assign err        = err_q;
    assign tick_count = tc_q;

endmodule
